// File: rtl/mor1kx_trace_sampler_if.sv
// Trace bundle from the mor1kx retire stage plus the event stream
// handed to the debug packetizer.
interface mor1kx_trace_sampler_if;
    logic [31:0] trace_insn;
    logic [31:0] trace_pc;
    logic        trace_jb;
    logic        trace_jal;
    logic        trace_jr;
    logic [31:0] trace_jbtarget;
    logic        trace_valid;
    logic [31:0] trace_wbdata;
    logic [4:0]  trace_wbreg;
    logic        trace_wben;
    logic [65:0] out_data;
    logic        out_valid;
    logic        out_ready;

    modport slave (
        input  trace_insn, trace_pc, trace_jb, trace_jal, trace_jr,
        input  trace_jbtarget, trace_valid,
        input  trace_wbdata, trace_wbreg, trace_wben,
        input  out_ready,
        output out_data, out_valid
    );

    modport master (
        output trace_insn, trace_pc, trace_jb, trace_jal, trace_jr,
        output trace_jbtarget, trace_valid,
        output trace_wbdata, trace_wbreg, trace_wben,
        output out_ready,
        input  out_data, out_valid
    );
endinterface

// File: rtl/mor1kx_trace_sampler.sv
// Extracts call/return events from the mor1kx trace port into a small FIFO;
// events lost to a full FIFO are reported later as a single OVF record.
module mor1kx_trace_sampler #(
    parameter int FIFO_DEPTH = 4,
    parameter int DROP_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    mor1kx_trace_sampler_if.slave tr,
    output logic [DROP_WIDTH-1:0] drop_cnt
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] T_CALL = 2'b01;
    localparam logic [1:0] T_RET  = 2'b10;
    localparam logic [1:0] T_OVF  = 2'b11;

    logic [65:0]           mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DROP_WIDTH-1:0] drop_q, drop_d;

    logic        is_call;
    logic        is_ret;
    logic        ev_hit;
    logic [65:0] ev_rec;
    logic [65:0] ovf_rec;
    logic [65:0] push_rec;
    logic        full;
    logic        push;
    logic        pop;

    // Return is l.jr r9: the link register of the OpenRISC ABI.
    assign is_call = tr.trace_jal;
    assign is_ret  = !tr.trace_jal && tr.trace_jr &&
                     (tr.trace_insn[15:11] == 5'd9);
    assign ev_hit  = tr.trace_valid && enable && tr.trace_jb &&
                     (is_call || is_ret);
    assign ev_rec  = {is_call ? T_CALL : T_RET,
                      tr.trace_pc, tr.trace_jbtarget};
    assign ovf_rec = {T_OVF, 32'h0, 32'(drop_q)};

    assign full = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop  = (count_q != '0) && tr.out_ready;

    always_comb begin
        push     = 1'b0;
        push_rec = ev_rec;
        drop_d   = drop_q;
        if ((drop_q != '0) && !full) begin
            push     = 1'b1;
            push_rec = ovf_rec;
            drop_d   = ev_hit ? DROP_WIDTH'(1) : '0;
        end else if (ev_hit && !full) begin
            push = 1'b1;
        end else if (ev_hit && full) begin
            drop_d = (&drop_q) ? drop_q : drop_q + DROP_WIDTH'(1);
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
            if (push) begin
                mem_q[wr_ptr_q] <= push_rec;
            end
        end
    end

    assign tr.out_valid = (count_q != '0);
    assign tr.out_data  = mem_q[rd_ptr_q];
    assign drop_cnt     = drop_q;

    // Write-back side of the trace port carries no flow information.
    logic unused_ok;
    assign unused_ok = ^{tr.trace_wbdata, tr.trace_wbreg, tr.trace_wben,
                         tr.trace_insn[31:16], tr.trace_insn[10:0]};
endmodule

// File: tb/tb_mor1kx_trace_sampler.sv
// Bench for mor1kx_trace_sampler: decode vectors from a table, then
// fill/drop, overflow, saturation, backpressure and reset sequences.
module tb_mor1kx_trace_sampler;
    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [3:0] drop_cnt;

    mor1kx_trace_sampler_if bus ();

    mor1kx_trace_sampler #(.FIFO_DEPTH(4), .DROP_WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .tr       (bus.slave),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        tv, jb, jal, jr;
        logic [4:0]  rb;
        logic [31:0] pc, tgt;
        logic        hit;
        logic [1:0]  typ;
    } vec_t;

    vec_t        vecs [8];
    logic [65:0] sb [$];
    int          checks = 0;
    int          errors = 0;
    logic        stall_q = 1'b0;
    logic [65:0] held = '0;

    task automatic check(string name, logic [65:0] act, logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic tv, logic jb, logic jal, logic jr,
                         logic [4:0] rb, logic [31:0] pc, logic [31:0] tgt);
        logic [31:0] insn;
        insn = $urandom;
        insn[15:11] = rb;
        bus.trace_insn     = insn;
        bus.trace_valid    = tv;
        bus.trace_jb       = jb;
        bus.trace_jal      = jal;
        bus.trace_jr       = jr;
        bus.trace_pc       = pc;
        bus.trace_jbtarget = tgt;
        bus.trace_wbdata   = $urandom;
        bus.trace_wbreg    = 5'($urandom);
        bus.trace_wben     = 1'($urandom);
    endtask

    task automatic call(logic [31:0] pc, logic [31:0] tgt);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, pc, tgt);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    endtask

    // Samples at the falling edge, then returns just after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (stall_q) begin
            check("hold_valid", 66'(bus.out_valid), 66'(1));
            check("hold_data", bus.out_data, held);
        end
        stall_q = bus.out_valid && !bus.out_ready;
        held    = bus.out_data;
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got %h expected none",
                         bus.out_data);
            end else begin
                check("out_data", bus.out_data, sb.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(string name);
        for (int i = 0; i < 30 && sb.size() != 0; i++) tick();
        check(name, 66'(sb.size()), 66'(0));
    endtask

    initial begin
        vecs[0] = '{1, 1, 1, 0, 5'd0, 32'h100,  32'h2000, 1, 2'b01};
        vecs[1] = '{1, 1, 0, 1, 5'd9, 32'h2010, 32'h104,  1, 2'b10};
        vecs[2] = '{1, 1, 0, 1, 5'd3, 32'h2014, 32'h108,  0, 2'b00};
        vecs[3] = '{1, 1, 1, 1, 5'd9, 32'h120,  32'h3000, 1, 2'b01};
        vecs[4] = '{1, 1, 0, 0, 5'd9, 32'h124,  32'h3004, 0, 2'b00};
        vecs[5] = '{1, 1, 1, 0, 5'd3, 32'h128,  32'h3008, 1, 2'b01};
        vecs[6] = '{1, 0, 1, 0, 5'd9, 32'h12c,  32'h300c, 0, 2'b00};
        vecs[7] = '{0, 1, 1, 0, 5'd9, 32'h130,  32'h3010, 0, 2'b00};

        rst = 1'b1;
        enable = 1'b1;
        bus.out_ready = 1'b1;
        idle();
        #12;
        check("rst_valid", 66'(bus.out_valid), 66'(0));
        check("rst_drop", 66'(drop_cnt), 66'(0));
        check("rst_data", bus.out_data, 66'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        foreach (vecs[k]) begin
            drive(vecs[k].tv, vecs[k].jb, vecs[k].jal, vecs[k].jr,
                  vecs[k].rb, vecs[k].pc, vecs[k].tgt);
            tick();
            idle();
            if (vecs[k].hit) sb.push_back({vecs[k].typ, vecs[k].pc, vecs[k].tgt});
            check($sformatf("v%0d_valid", k), 66'(bus.out_valid), 66'(vecs[k].hit));
            tick();
            check($sformatf("v%0d_after", k), 66'(bus.out_valid), 66'(0));
            check($sformatf("v%0d_sb", k), 66'(sb.size()), 66'(0));
        end

        // Seven calls into a stalled 4-deep FIFO.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            call(32'h300 + 32'(i * 4), 32'h4000 + 32'(i));
            if (i < 4) sb.push_back({2'b01, 32'h300 + 32'(i * 4), 32'h4000 + 32'(i)});
            tick();
        end
        idle();
        check("fill_valid", 66'(bus.out_valid), 66'(1));
        check("fill_drop", 66'(drop_cnt), 66'(3));
        sb.push_back({2'b11, 32'h0, 32'h3});
        bus.out_ready = 1'b1;
        drain("fill_drain");
        check("fill_drop0", 66'(drop_cnt), 66'(0));
        check("fill_empty", 66'(bus.out_valid), 66'(0));

        // OVF push coinciding with a fresh call.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            call(32'h500 + 32'(i), 32'h5000 + 32'(i));
            if (i < 4) sb.push_back({2'b01, 32'h500 + 32'(i), 32'h5000 + 32'(i)});
            tick();
        end
        idle();
        check("ovf_drop2", 66'(drop_cnt), 66'(2));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        call(32'h600, 32'h7000);
        tick();
        idle();
        check("ovf_drop1", 66'(drop_cnt), 66'(1));
        sb.push_back({2'b11, 32'h0, 32'h2});
        sb.push_back({2'b11, 32'h0, 32'h1});
        bus.out_ready = 1'b1;
        drain("ovf_drain");
        check("ovf_drop0", 66'(drop_cnt), 66'(0));

        // Saturation, then enable gating while draining.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 24; i++) begin
            call(32'h800 + 32'(i), 32'h8800 + 32'(i));
            if (i < 4) sb.push_back({2'b01, 32'h800 + 32'(i), 32'h8800 + 32'(i)});
            tick();
        end
        check("sat_drop", 66'(drop_cnt), 66'(15));
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            call(32'h900 + 32'(i), 32'h9900);
            tick();
        end
        check("en_drop", 66'(drop_cnt), 66'(15));
        check("en_valid", 66'(bus.out_valid), 66'(1));
        sb.push_back({2'b11, 32'h0, 32'hf});
        bus.out_ready = 1'b1;
        drain("sat_drain");
        check("sat_drop0", 66'(drop_cnt), 66'(0));
        for (int i = 0; i < 3; i++) tick();
        check("en_idle", 66'(bus.out_valid), 66'(0));
        idle();
        enable = 1'b1;

        // Toggling backpressure over a three-call burst.
        for (int i = 0; i < 8; i++) begin
            bus.out_ready = (i % 2 == 0);
            if (i < 3) begin
                call(32'hA00 + 32'(i), 32'hB00 + 32'(i));
                sb.push_back({2'b01, 32'hA00 + 32'(i), 32'hB00 + 32'(i)});
            end else begin
                idle();
            end
            tick();
        end
        bus.out_ready = 1'b1;
        drain("bp_drain");
        check("bp_empty", 66'(bus.out_valid), 66'(0));

        // Asynchronous reset in the middle of a dropping burst.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            call(32'hC00 + 32'(i), 32'hD00);
            tick();
        end
        idle();
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 66'(bus.out_valid), 66'(0));
        check("arst_drop", 66'(drop_cnt), 66'(0));
        sb.delete();
        stall_q = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("post_rst_valid", 66'(bus.out_valid), 66'(0));
        check("post_rst_data", bus.out_data, 66'(0));
        call(32'hE00, 32'hF00);
        sb.push_back({2'b01, 32'hE00, 32'hF00});
        tick();
        idle();
        drain("post_rst_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mor1kx_trace_sampler.md
Name: mor1kx_trace_sampler

Overview:
- Consumer end of the mor1kx execution-trace interface: samples the per-retired-instruction trace bundle and extracts program-flow events (call, return).
- Buffers events in a small FIFO and presents them as a valid/ready stream to the debug packetizer.
- Sits between the mor1kx trace port and the CPU trace module of the debug system.
- Lost events are accounted for with an overflow record, never silently discarded.

Parameters:
- FIFO_DEPTH, 4: event FIFO entries; power of two, >= 2.
- DROP_WIDTH, 16: width of the saturating dropped-event counter (<= 32).

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  capture enable; sampled each cycle
- trace_insn  in  32  retired instruction word
- trace_pc  in  32  PC of retired instruction
- trace_jb  in  1  instruction is jump/branch
- trace_jal  in  1  instruction links (l.jal / l.jalr)
- trace_jr  in  1  register-indirect jump
- trace_jbtarget  in  32  jump/branch target
- trace_valid  in  1  trace bundle valid this cycle
- trace_wbdata, trace_wbreg, trace_wben  in  32/5/1  accepted, unused
- out_data  out  66  {type[1:0], pc[31:0], target[31:0]}
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts when out_valid & out_ready
- drop_cnt  out  DROP_WIDTH  current pending dropped-event count

Behaviour:
- Event detection (combinational, qualified by trace_valid & enable & trace_jb):
  - CALL, type 2'b01: trace_jal=1. Takes priority over RET.
  - RET, type 2'b10: trace_jal=0, trace_jr=1, rB field trace_insn[15:11]==5'd9.
  - Anything else produces no event.
  - Record fields: pc=trace_pc, target=trace_jbtarget.
- OVF record, type 2'b11: pc=0, target = drop_cnt zero-extended to 32 bits.
- FIFO:
  - Registered occupancy count 0..FIFO_DEPTH; read/write pointers wrap modulo FIFO_DEPTH.
  - full = (count == FIFO_DEPTH). A push is refused when full, even if a pop happens in the same cycle.
  - Pop occurs on out_valid & out_ready.
- Per-cycle push decision, evaluated in this order:
  1. drop_cnt != 0 and not full: push OVF; drop_cnt <= (event ? 1 : 0). The same-cycle event is counted as dropped.
  2. event and not full: push event.
  3. event and full: drop_cnt <= drop_cnt+1, saturating at all-ones.
- Output timing:
  - out_valid = (count != 0); out_data = FIFO head.
  - Latency: event on cycle N appears at out_valid on cycle N+1 when the FIFO was empty.
  - out_data is stable while out_valid & !out_ready.
  - Simultaneous push and pop at non-full: count unchanged, both take effect.
- enable deassertion:
  - Stops detection only.
  - The FIFO continues to drain.
  - A pending drop_cnt is still flushed as OVF when space frees.
- Reset (async assert, sync deassert handled upstream):
  - count=0, pointers=0, drop_cnt=0, out_valid=0, out_data=0.
  - Reset mid-operation discards buffered events and the pending drop count.
- trace_wb* inputs have no effect on any output.

Test Plan:
- Reset, then single CALL: trace_valid=1, jb=1, jal=1, pc=0x100, target=0x2000, out_ready=1 -> next cycle out_valid=1, out_data={01,0x100,0x2000}; following cycle out_valid=0.
- RET discrimination:
  - jr=1, jal=0, insn[15:11]=9, pc=0x2010, target=0x104 -> {10,0x2010,0x104}.
  - Same with insn[15:11]=3 -> no output.
  - jal=1 & jr=1 -> CALL.
- Fill and drop: out_ready=0, FIFO_DEPTH=4, seven consecutive CALLs -> out_valid=1, drop_cnt=3. Then out_ready=1 with no further events -> 4 CALLs in order, then OVF {11,0,0x3}; drop_cnt returns 0.
- Overflow with same-cycle event: drop_cnt=2, one slot frees, CALL arrives in the same cycle -> OVF(target=2) pushed, drop_cnt=1; next free slot yields OVF(target=1).
- Saturation and enable: DROP_WIDTH=4, FIFO full, 20 events -> drop_cnt=0xF. Events with enable=0 -> no change to drop_cnt or FIFO.
- Backpressure and reset: out_ready toggles 1/0 every cycle during a burst of 3 events -> out_data holds while stalled, order preserved, no duplicates. Assert rst mid-burst -> out_valid=0 and drop_cnt=0 asynchronously.
